// File: rtl/reg_operand_fetch.sv
// Operand fetch stage: reads two source operands from the register file outputs,
// with write-through forwarding on the fetch edge, and offers them via valid/ack.
module reg_operand_fetch #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NREG  = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [WIDTH*NREG-1:0] r_flat,
    input  logic [WIDTH-1:0]      b0_q,
    input  logic [WIDTH-1:0]      s_bus,
    input  logic [NREG-1:0]       sr,
    input  logic                  sb0,
    input  logic                  rd_req,
    input  logic [3:0]            sel_a,
    input  logic [3:0]            sel_b,
    output logic                  rd_ready,
    input  logic                  flush,
    output logic [WIDTH-1:0]      op_a,
    output logic [WIDTH-1:0]      op_b,
    output logic                  op_valid,
    output logic                  op_err,
    input  logic                  op_ack
);

    typedef enum logic [1:0] {IDLE, RD_A, RD_B, VALID} state_t;

    state_t           state_q, state_d;
    logic [3:0]       sel_a_q, sel_a_d;
    logic [3:0]       sel_b_q, sel_b_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_err_q, op_err_d;

    logic [3:0]       cur_sel;
    logic [WIDTH-1:0] fetch_val;
    logic             fetch_err;
    logic             accept;

    // One shared source mux: RD_A reads via sel_a_q, RD_B via sel_b_q.
    always_comb begin
        cur_sel   = (state_q == RD_B) ? sel_b_q : sel_a_q;
        fetch_val = '0;
        fetch_err = 1'b1;
        for (int unsigned j = 0; j < NREG; j++) begin
            if (cur_sel == 4'(j)) begin
                fetch_val = sr[j] ? s_bus : r_flat[j*WIDTH +: WIDTH];
                fetch_err = 1'b0;
            end
        end
        if (cur_sel == 4'd8) begin
            fetch_val = sb0 ? s_bus : b0_q;
            fetch_err = 1'b0;
        end else if (cur_sel == 4'd9) begin
            fetch_err = 1'b0;
        end
    end

    assign rd_ready = (state_q == IDLE) || ((state_q == VALID) && op_ack);
    assign accept   = rd_req && rd_ready && !flush;

    always_comb begin
        state_d  = state_q;
        sel_a_d  = sel_a_q;
        sel_b_d  = sel_b_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_err_d = op_err_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sel_a_d  = sel_a;
                        sel_b_d  = sel_b;
                        op_err_d = 1'b0;
                        state_d  = RD_A;
                    end
                end
                RD_A: begin
                    op_a_d = fetch_val;
                    if (fetch_err) op_err_d = 1'b1;
                    state_d = RD_B;
                end
                RD_B: begin
                    op_b_d = fetch_val;
                    if (fetch_err) op_err_d = 1'b1;
                    state_d = VALID;
                end
                VALID: begin
                    if (op_ack) begin
                        if (accept) begin
                            sel_a_d  = sel_a;
                            sel_b_d  = sel_b;
                            op_err_d = 1'b0;
                            state_d  = RD_A;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_err_q <= op_err_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_err   = op_err_q;
    assign op_valid = (state_q == VALID);

endmodule
